// File: rtl/alu_wide_seq_pkg.sv
// rtl/alu_wide_seq_pkg.sv - shared types and constants for the wide ALU sequencer
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WORD_W_DEFAULT    = 16;
  localparam int NUM_WORDS_DEFAULT = 2;

  // Select/mode pairs understood by the downstream 16-bit ALU
  localparam logic [3:0] SEL_ADD     = 4'b1001;
  localparam logic       MODE_ADD    = 1'b1;
  localparam logic [3:0] SEL_XOR     = 4'b0110;
  localparam logic       MODE_XOR    = 1'b0;
  localparam logic [3:0] SEL_PASS_A  = 4'b1111;
  localparam logic       MODE_PASS_A = 1'b0;

  function automatic int idx_width(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

endpackage

// File: rtl/alu_wide_seq_if.sv
// rtl/alu_wide_seq_if.sv - command, response and ALU-side signals of the sequencer
interface alu_wide_seq_if #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 2
);

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [WORD_W*NUM_WORDS-1:0] cmd_a;
  logic [WORD_W*NUM_WORDS-1:0] cmd_b;
  logic [3:0]                  cmd_select;
  logic                        cmd_mode;
  logic                        cmd_carry_in;
  logic                        cmd_wide;

  logic [WORD_W-1:0]           alu_in_a;
  logic [WORD_W-1:0]           alu_in_b;
  logic [3:0]                  alu_select;
  logic                        alu_mode;
  logic                        alu_carry_in;
  logic [WORD_W-1:0]           alu_out;
  logic                        alu_carry_out;
  logic                        alu_compare;

  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [WORD_W*NUM_WORDS-1:0] rsp_result;
  logic                        rsp_carry;
  logic                        rsp_equal;

  // Environment side: command producer, ALU and response consumer
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_select, cmd_mode, cmd_carry_in, cmd_wide,
    input  cmd_ready,
    input  alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
    output alu_out, alu_carry_out, alu_compare,
    input  rsp_valid, rsp_result, rsp_carry, rsp_equal,
    output rsp_ready
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_select, cmd_mode, cmd_carry_in, cmd_wide,
    output cmd_ready,
    output alu_in_a, alu_in_b, alu_select, alu_mode, alu_carry_in,
    input  alu_out, alu_carry_out, alu_compare,
    output rsp_valid, rsp_result, rsp_carry, rsp_equal,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_wide_seq.sv
// rtl/alu_wide_seq.sv - drives a WORD_W ALU slice by slice for wide operations
// Optional overlap of response and next command: define ALU_SEQ_B2B_EN.
module alu_wide_seq
  import alu_seq_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEFAULT,
  parameter int NUM_WORDS = NUM_WORDS_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  alu_wide_seq_if.slave bus
);

  localparam int FULL_W = WORD_W * NUM_WORDS;
  localparam int IDX_W  = idx_width(NUM_WORDS);

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic [FULL_W-1:0]  r_a;
  logic [FULL_W-1:0]  r_b;
  logic [FULL_W-1:0]  r_result;
  logic [3:0]         r_sel;
  logic               r_mode;
  logic               r_cin;
  logic               r_wide;
  logic               r_carry;
  logic               r_equal;

  logic               w_cmd_ready;
  logic               w_cmd_fire;
  logic               w_rsp_fire;
  logic               w_last;
  logic [IDX_W-1:0]   w_last_idx;
  int                 w_base;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_last_idx = r_wide ? IDX_W'(NUM_WORDS - 1) : '0;
    w_last     = (r_idx == w_last_idx);
    w_rsp_fire = (r_state == ST_DONE) && bus.rsp_ready;
    w_base     = int'(r_idx) * WORD_W;

    w_cmd_ready = 1'b0;
    if (rst) begin
      if (r_state == ST_IDLE) begin
        w_cmd_ready = 1'b1;
      end
`ifdef ALU_SEQ_B2B_EN
      if (w_rsp_fire) begin
        w_cmd_ready = 1'b1;
      end
`endif
    end
    w_cmd_fire = bus.cmd_valid && w_cmd_ready;

    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_cmd_fire) w_next_state = ST_RUN;
      ST_RUN:  if (w_last)     w_next_state = ST_DONE;
      // A command can only fire in DONE when the overlap option is built in
      ST_DONE: if (w_rsp_fire) w_next_state = w_cmd_fire ? ST_RUN : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase

    bus.alu_in_a     = '0;
    bus.alu_in_b     = '0;
    bus.alu_select   = '0;
    bus.alu_mode     = 1'b0;
    bus.alu_carry_in = 1'b0;
    if (r_state == ST_RUN) begin
      bus.alu_in_a     = r_a[w_base +: WORD_W];
      bus.alu_in_b     = r_b[w_base +: WORD_W];
      bus.alu_select   = r_sel;
      bus.alu_mode     = r_mode;
      bus.alu_carry_in = (r_idx == '0) ? r_cin : r_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= '0;
      r_mode   <= 1'b0;
      r_cin    <= 1'b0;
      r_wide   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_equal  <= 1'b0;
    end else if (w_cmd_fire) begin
      r_idx    <= '0;
      r_a      <= bus.cmd_a;
      r_b      <= bus.cmd_b;
      r_sel    <= bus.cmd_select;
      r_mode   <= bus.cmd_mode;
      r_cin    <= bus.cmd_carry_in;
      r_wide   <= bus.cmd_wide;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_equal  <= 1'b1;
    end else if (r_state == ST_RUN) begin
      r_result[w_base +: WORD_W] <= bus.alu_out;
      r_carry                    <= bus.alu_carry_out;
      r_equal                    <= r_equal & bus.alu_compare;
      if (!w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.rsp_valid  = (r_state == ST_DONE);
  assign bus.rsp_result = r_result;
  assign bus.rsp_carry  = r_carry;
  assign bus.rsp_equal  = r_equal;

endmodule

// File: tb/tb_alu_wide_seq.sv
// tb/tb_alu_wide_seq.sv - directed self-checking bench for alu_wide_seq with a 16-bit ALU model
module tb_alu_wide_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [16:0] sum;

  always #5 clk = ~clk;

  alu_wide_seq_if #(.WORD_W(16), .NUM_WORDS(2)) bus ();

  alu_wide_seq #(.WORD_W(16), .NUM_WORDS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference ALU slice: add returns a 17-bit sum whose MSB is the carry
  always_comb begin
    sum               = {1'b0, bus.alu_in_a} + {1'b0, bus.alu_in_b} + {16'd0, bus.alu_carry_in};
    bus.alu_out       = 16'd0;
    bus.alu_carry_out = 1'b0;
    bus.alu_compare   = (bus.alu_in_a == bus.alu_in_b);
    if (bus.alu_select == SEL_ADD && bus.alu_mode == MODE_ADD) begin
      bus.alu_out       = sum[15:0];
      bus.alu_carry_out = sum[16];
    end else if (bus.alu_select == SEL_XOR && bus.alu_mode == MODE_XOR) begin
      bus.alu_out = bus.alu_in_a ^ bus.alu_in_b;
    end else if (bus.alu_select == SEL_PASS_A && bus.alu_mode == MODE_PASS_A) begin
      bus.alu_out = bus.alu_in_a;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                          input logic mode, input logic cin, input logic wide, output bit ok);
    bus.cmd_a        = a;
    bus.cmd_b        = b;
    bus.cmd_select   = sel;
    bus.cmd_mode     = mode;
    bus.cmd_carry_in = cin;
    bus.cmd_wide     = wide;
    bus.cmd_valid    = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.cmd_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!bus.rsp_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=0", bus.cmd_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.rsp_result !== 32'h0) begin bad++; $display("FAIL reset_rsp_result got=%h exp=0", bus.rsp_result); end
    total++; if (bus.rsp_equal !== 1'b0) begin bad++; $display("FAIL reset_rsp_equal got=%b exp=0", bus.rsp_equal); end
    total++; if (bus.alu_in_a !== 16'h0 || bus.alu_select !== 4'h0) begin bad++; $display("FAIL reset_alu_drive got=%h/%h exp=0/0", bus.alu_in_a, bus.alu_select); end
    rst = 1'b1;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_cmd_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_wide_add();
    bit ok;
    int cyc;
    send_cmd(32'h0001_FFFF, 32'h0000_0001, SEL_ADD, MODE_ADD, 1'b0, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL wide_add_accept got=timeout exp=accept"); end
    wait_rsp(cyc);
    total++; if (cyc !== 2) begin bad++; $display("FAIL wide_add_latency got=%0d exp=2", cyc); end
    total++; if (bus.rsp_result !== 32'h0002_0000) begin bad++; $display("FAIL wide_add_result got=%h exp=00020000", bus.rsp_result); end
    total++; if (bus.rsp_carry !== 1'b0) begin bad++; $display("FAIL wide_add_carry got=%b exp=0", bus.rsp_carry); end
    take_rsp();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL wide_add_drop got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.rsp_result !== 32'h0002_0000) begin bad++; $display("FAIL wide_add_hold got=%h exp=00020000", bus.rsp_result); end
  endtask

  task automatic test_wide_overflow();
    bit ok;
    send_cmd(32'hFFFF_FFFF, 32'h0000_0001, SEL_ADD, MODE_ADD, 1'b0, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_accept got=timeout exp=accept"); end
    total++; if (bus.alu_select !== SEL_ADD || bus.alu_mode !== MODE_ADD) begin bad++; $display("FAIL ovf_fwd got=%b/%b exp=1001/1", bus.alu_select, bus.alu_mode); end
    total++; if (bus.alu_carry_in !== 1'b0 || bus.alu_in_a !== 16'hFFFF) begin bad++; $display("FAIL ovf_slice0 got=%b/%h exp=0/ffff", bus.alu_carry_in, bus.alu_in_a); end
    step();
    total++; if (bus.alu_carry_in !== 1'b1) begin bad++; $display("FAIL ovf_slice1_cin got=%b exp=1", bus.alu_carry_in); end
    total++; if (bus.alu_in_b !== 16'h0000 || bus.alu_in_a !== 16'hFFFF) begin bad++; $display("FAIL ovf_slice1_ops got=%h/%h exp=ffff/0000", bus.alu_in_a, bus.alu_in_b); end
    step();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", bus.rsp_valid); end
    total++; if (bus.rsp_result !== 32'h0) begin bad++; $display("FAIL ovf_result got=%h exp=00000000", bus.rsp_result); end
    total++; if (bus.rsp_carry !== 1'b1) begin bad++; $display("FAIL ovf_carry got=%b exp=1", bus.rsp_carry); end
    take_rsp();
  endtask

  task automatic test_narrow_xor();
    bit ok;
    int cyc;
    send_cmd(32'h1234_00FF, 32'hABCD_0F0F, SEL_XOR, MODE_XOR, 1'b0, 1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL xor_accept got=timeout exp=accept"); end
    wait_rsp(cyc);
    total++; if (cyc !== 1) begin bad++; $display("FAIL xor_latency got=%0d exp=1", cyc); end
    total++; if (bus.rsp_result !== 32'h0000_0FF0) begin bad++; $display("FAIL xor_result got=%h exp=00000ff0", bus.rsp_result); end
    total++; if (bus.rsp_equal !== 1'b0) begin bad++; $display("FAIL xor_equal got=%b exp=0", bus.rsp_equal); end
    take_rsp();
  endtask

  task automatic test_equality();
    bit ok;
    int cyc;
    send_cmd(32'h5A5A_A5A5, 32'h5A5A_A5A5, SEL_PASS_A, MODE_PASS_A, 1'b0, 1'b1, ok);
    wait_rsp(cyc);
    total++; if (!ok || cyc !== 2) begin bad++; $display("FAIL eq_handshake got=%b/%0d exp=1/2", ok, cyc); end
    total++; if (bus.rsp_equal !== 1'b1) begin bad++; $display("FAIL eq_same got=%b exp=1", bus.rsp_equal); end
    total++; if (bus.rsp_result !== 32'h5A5A_A5A5) begin bad++; $display("FAIL eq_pass_result got=%h exp=5a5aa5a5", bus.rsp_result); end
    take_rsp();
    send_cmd(32'h5A5A_A5A5, 32'h5A5B_A5A5, SEL_PASS_A, MODE_PASS_A, 1'b0, 1'b1, ok);
    wait_rsp(cyc);
    total++; if (bus.rsp_equal !== 1'b0) begin bad++; $display("FAIL eq_high_diff got=%b exp=0", bus.rsp_equal); end
    take_rsp();
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    send_cmd(32'h0000_0001, 32'h0000_0002, SEL_ADD, MODE_ADD, 1'b0, 1'b1, ok);
    wait_rsp(cyc);
    total++; if (!ok || cyc !== 2) begin bad++; $display("FAIL bp_handshake got=%b/%0d exp=1/2", ok, cyc); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.cmd_a     = 32'h7777_7777;
        bus.cmd_valid = 1'b1;
      end
      #1;
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h3 || bus.rsp_carry !== 1'b0) begin
        bad++; $display("FAIL bp_stable cycle=%0d got=%b/%h/%b exp=1/00000003/0", i, bus.rsp_valid, bus.rsp_result, bus.rsp_carry); end
      total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_cmd_ready cycle=%0d got=%b exp=0", i, bus.cmd_ready); end
      step();
      bus.cmd_valid = 1'b0;
    end
    take_rsp();
    step();
    total++; if (bus.rsp_valid !== 1'b0 || bus.alu_in_a !== 16'h0) begin bad++; $display("FAIL bp_pulse_ignored got=%b/%h exp=0/0000", bus.rsp_valid, bus.alu_in_a); end
    total++; if (bus.rsp_result !== 32'h3) begin bad++; $display("FAIL bp_hold got=%h exp=00000003", bus.rsp_result); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int cyc;
    send_cmd(32'h0003_0005, 32'h0001_0002, SEL_ADD, MODE_ADD, 1'b0, 1'b1, ok);
    step();
    total++; if (bus.alu_in_a !== 16'h0003) begin bad++; $display("FAIL rst_run_idx1 got=%h exp=0003", bus.alu_in_a); end
    rst = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_run_cmd_ready got=%b exp=0", bus.cmd_ready); end
    step();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_run_valid got=%b exp=0", bus.rsp_valid); end
    total++; if (bus.rsp_result !== 32'h0) begin bad++; $display("FAIL rst_run_result got=%h exp=00000000", bus.rsp_result); end
    total++; if (bus.alu_in_a !== 16'h0 || bus.alu_mode !== 1'b0) begin bad++; $display("FAIL rst_run_idle_drive got=%h/%b exp=0000/0", bus.alu_in_a, bus.alu_mode); end
    rst = 1'b1;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_run_release got=%b exp=1", bus.cmd_ready); end
    send_cmd(32'h0010_0020, 32'h0001_0001, SEL_ADD, MODE_ADD, 1'b0, 1'b1, ok);
    wait_rsp(cyc);
    total++; if (!ok || cyc !== 2 || bus.rsp_result !== 32'h0011_0021) begin
      bad++; $display("FAIL rst_run_after got=%b/%0d/%h exp=1/2/00110021", ok, cyc, bus.rsp_result); end
    take_rsp();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int cyc;
    send_cmd(32'h0000_0005, 32'h0000_0006, SEL_ADD, MODE_ADD, 1'b0, 1'b1, ok);
    wait_rsp(cyc);
    total++; if (!ok || bus.rsp_result !== 32'h0000_000B) begin bad++; $display("FAIL b2b_first got=%h exp=0000000b", bus.rsp_result); end
    bus.cmd_a      = 32'h0002_0003;
    bus.cmd_b      = 32'h0004_0005;
    bus.cmd_select = SEL_ADD;
    bus.cmd_mode   = MODE_ADD;
    bus.cmd_wide   = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.rsp_ready  = 1'b1;
    #1;
`ifdef ALU_SEQ_B2B_EN
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.cmd_ready); end
    step();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    total++; if (bus.rsp_valid !== 1'b0 || bus.alu_in_a !== 16'h0003) begin bad++; $display("FAIL b2b_run got=%b/%h exp=0/0003", bus.rsp_valid, bus.alu_in_a); end
`else
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready got=%b exp=0", bus.cmd_ready); end
    step();
    bus.rsp_ready = 1'b0;
    total++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b/%b exp=0/1", bus.rsp_valid, bus.cmd_ready); end
    step();
    bus.cmd_valid = 1'b0;
`endif
    wait_rsp(cyc);
    total++; if (cyc !== 2 || bus.rsp_result !== 32'h0006_0008) begin bad++; $display("FAIL b2b_second got=%0d/%h exp=2/00060008", cyc, bus.rsp_result); end
    take_rsp();
  endtask

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd_a        = '0;
    bus.cmd_b        = '0;
    bus.cmd_select   = '0;
    bus.cmd_mode     = 1'b0;
    bus.cmd_carry_in = 1'b0;
    bus.cmd_wide     = 1'b0;
    bus.rsp_ready    = 1'b0;
    test_reset();
    test_wide_add();
    test_wide_overflow();
    test_narrow_xor();
    test_equality();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
Multi-word operation sequencer that sits directly upstream of the 16-bit ALU and also consumes its outputs. It accepts a wide command over a valid/ready handshake and drives the ALU one WORD_W slice per cycle, low word first, chaining the ALU carry between slices. It assembles the result and returns it on a response handshake. This gives 32-bit logic and arithmetic operations on the existing 16-bit datapath.

Parameters:
WORD_W, 16, ALU slice width; must equal the ALU data width.
NUM_WORDS, 2, slices per wide operation; full operand width = WORD_W*NUM_WORDS.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset; synchronous, active-low.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command.
cmd_a  in  WORD_W*NUM_WORDS  operand A.
cmd_b  in  WORD_W*NUM_WORDS  operand B.
cmd_select  in  4  ALU function select, forwarded unchanged to every slice.
cmd_mode  in  1  0 = logic, 1 = arithmetic; forwarded unchanged to every slice.
cmd_carry_in  in  1  carry into slice 0.
cmd_wide  in  1  1 = all NUM_WORDS slices; 0 = slice 0 only.
alu_in_a  out  WORD_W  current A slice to the ALU.
alu_in_b  out  WORD_W  current B slice to the ALU.
alu_select  out  4  to the ALU.
alu_mode  out  1  to the ALU.
alu_carry_in  out  1  to the ALU.
alu_out  in  WORD_W  combinational ALU result.
alu_carry_out  in  1  ALU carry.
alu_compare  in  1  ALU slice equality.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer accepts the result.
rsp_result  out  WORD_W*NUM_WORDS  assembled result; upper slices are 0 when cmd_wide=0.
rsp_carry  out  1  alu_carry_out of the last slice processed.
rsp_equal  out  1  AND of alu_compare over all slices processed.

Behaviour:
- States: IDLE, RUN, DONE. A word index idx runs 0..NUM_WORDS-1.
- Reset (rst low at an edge), from any state including mid-RUN:
  - state = IDLE, idx = 0, the in-flight command is discarded.
  - rsp_valid = 0, rsp_result = 0, rsp_carry = 0, rsp_equal = 0.
  - cmd_ready = 0 while rst is low.
- cmd_ready = 1 only in IDLE (out of reset).
- IDLE: on cmd_valid && cmd_ready, register all cmd_* fields, clear result, set equal accumulator = 1, idx = 0, go to RUN.
- RUN, each cycle:
  - Drive alu_in_a/alu_in_b with slice idx of the registered operands, plus the registered select and mode.
  - alu_carry_in = cmd_carry_in when idx = 0, otherwise the carry captured on the previous edge.
  - At the edge, capture alu_out into result slice idx, carry_reg <= alu_carry_out, equal <= equal & alu_compare.
  - If idx is the last slice (NUM_WORDS-1 when wide, 0 when narrow), go to DONE; else idx++.
- Latency: rsp_valid rises NUM_WORDS cycles after the accept edge for wide commands, 1 cycle for narrow. Throughput is one command per latency+2 cycles minimum.
- DONE:
  - rsp_valid = 1; rsp_* outputs are stable until handshake.
  - On rsp_valid && rsp_ready, go to IDLE and drop rsp_valid. rsp_result holds its last value.
- Outside RUN: alu_in_a = alu_in_b = 0, alu_select = 0, alu_mode = 0, alu_carry_in = 0.
- cmd_* changes while not in IDLE are ignored. rsp_ready outside DONE is ignored.
- Width rules:
  - No arithmetic is performed in this block; carry wrap-around is the ALU's.
  - rsp_carry reflects only the final slice.

Optional Feature:
ALU_SEQ_B2B_EN defined:
- cmd_ready is also 1 in DONE when rsp_ready = 1.
- A simultaneous response and command handshake goes straight from DONE to RUN, with idx = 0 and fresh registers.
- Throughput becomes one command per latency+1 cycles.

ALU_SEQ_B2B_EN undefined: cmd_ready is high in IDLE only, as described above.

Decomposition:
- Shared package alu_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the WORD_W default;
  - named select/mode constants: SEL_ADD = 4'b1001 with mode 1, SEL_XOR = 4'b0110 with mode 0, SEL_PASS_A = 4'b1111 with mode 0.
- No sub-module is required. Slice extraction is an indexed part-select inside the block.

Test Plan:
The bench pairs the block with an ALU model whose add (select 1001, mode 1) returns a 17-bit sum including carry_in, with the MSB as carry_out.
1. Wide add: A = 0x0001_FFFF, B = 0x0000_0001, carry_in = 0 -> rsp_result = 0x0002_0000, rsp_carry = 0, rsp_valid 2 cycles after accept.
2. Wide add overflow: A = 0xFFFF_FFFF, B = 0x0000_0001 -> rsp_result = 0x0000_0000, rsp_carry = 1; slice-1 alu_carry_in observed = 1.
3. Narrow XOR (select 0110, mode 0, cmd_wide = 0): A = 0x1234_00FF, B = 0xABCD_0F0F -> rsp_result = 0x0000_0FF0, latency 1, rsp_equal = 0.
4. Equality: A = B = 0x5A5A_A5A5 with pass-A -> rsp_equal = 1. Then change only the high slice of B -> rsp_equal = 0.
5. Backpressure: hold rsp_ready = 0 for 5 cycles in DONE -> rsp_* stable and cmd_ready = 0 throughout; a cmd_valid pulse in that window is not accepted.
6. Reset mid-RUN: assert rst low during idx = 1 -> next cycle state IDLE, rsp_valid = 0, rsp_result = 0. After release, a new command completes normally. With ALU_SEQ_B2B_EN, verify accept on the response-handshake cycle.
